// File: rtl/tetris_pkg.sv
// Shared constants and types for the game FSM,
// the collision scanner and the VGA field reader.
package tetris_pkg;

    localparam int FIELD_W = 20;
    localparam int FIELD_H = 24;
    localparam int CELLS   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } scan_state_e;

    // True when a piece cell lands at or beyond the field limit.
    // The 6-bit sum keeps pos + offset from wrapping.
    function automatic logic cell_oob(
        input logic [4:0] pos,
        input logic [1:0] off,
        input int         lim
    );
        logic [5:0] sum;
        sum = {1'b0, pos} + {4'b0000, off};
        return sum >= 6'(lim);
    endfunction

endpackage

// File: rtl/collision_scan_ctrl_lat_pipe.sv
// Fixed-depth shift register that tracks per-cell
// tags alongside the index/RAM read latency.
module lat_pipe #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH*WIDTH-1:0] taps
);

    logic [DEPTH-1:0][WIDTH-1:0] sr;

    // Shift one stage per clock, stalls included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign dout = sr[DEPTH-1];
    assign taps = sr;

endmodule

// File: rtl/collision_scan_ctrl.sv
// Walks the 16 cells of the active piece through the
// index datapath and reduces them to one collide verdict.
module collision_scan_ctrl
    import tetris_pkg::*;
#(
    parameter int FW     = FIELD_W,
    parameter int FH     = FIELD_H,
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [4:0] pos_x,
    input  logic [4:0] pos_y,
    input  logic [1:0] rot,
    input  logic       field_gnt,
    input  logic       shape_bit,
    input  logic       field_bit,
    output logic [4:0] block_pos_x,
    output logic [4:0] block_pos_y,
    output logic [1:0] rotate_out,
    output logic [1:0] b_x,
    output logic [1:0] b_y,
    output logic       field_req,
    output logic       busy,
    output logic       done,
    output logic       collide
);

    localparam logic [2*RD_LAT-1:0] VMASK = {RD_LAT{2'b10}};
    localparam logic [3:0]          LAST  = 4'(CELLS - 1);

    scan_state_e              state;
    logic [3:0]               cnt;
    logic                     acc;
    logic                     issue;
    logic                     oob_now;
    logic [1:0]               pipe_out;
    logic [2*RD_LAT-1:0]      taps;
    logic                     pipe_busy;
    logic                     hit;

    assign b_x   = cnt[1:0];
    assign b_y   = cnt[3:2];
    assign issue = field_req & field_gnt;

    // Out-of-field test for the cell being issued now.
    always_comb begin
        oob_now = cell_oob(block_pos_x, b_x, FW)
                | cell_oob(block_pos_y, b_y, FH);
    end

    lat_pipe #(
        .WIDTH (2),
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({issue, oob_now}),
        .dout  (pipe_out),
        .taps  (taps)
    );

    // Drain is finished once no valid tag remains in flight.
    always_comb begin
        pipe_busy = |(taps & VMASK);
        hit       = pipe_out[1] & shape_bit
                  & (field_bit | pipe_out[0]);
    end

    // Scan sequencer, cell counter and verdict accumulator.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= 1'b0;
            block_pos_x <= '0;
            block_pos_y <= '0;
            rotate_out  <= '0;
            field_req   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            collide     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (hit) begin
                acc <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        block_pos_x <= pos_x;
                        block_pos_y <= pos_y;
                        rotate_out  <= rot;
                        cnt         <= '0;
                        acc         <= 1'b0;
                        collide     <= 1'b0;
                        field_req   <= 1'b1;
                        busy        <= 1'b1;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (field_gnt) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == LAST) begin
                            field_req <= 1'b0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!pipe_busy) begin
                        collide <= acc;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Directed bench: index datapath, shape ROM and a
// 1-cycle field RAM modelled around the scanner.
module tb_collision_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [4:0] pos_x;
    logic [4:0] pos_y;
    logic [1:0] rot;
    logic       field_gnt;
    logic       shape_bit;
    logic       field_bit;
    logic [4:0] block_pos_x;
    logic [4:0] block_pos_y;
    logic [1:0] rotate_out;
    logic [1:0] b_x;
    logic [1:0] b_y;
    logic       field_req;
    logic       busy;
    logic       done;
    logic       collide;

    int checks   = 0;
    int failures = 0;

    logic [479:0] fmem;
    logic [15:0]  shape_rom [4];
    logic         sh1;
    logic         fb1;

    collision_scan_ctrl #(.RD_LAT(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .rot         (rot),
        .field_gnt   (field_gnt),
        .shape_bit   (shape_bit),
        .field_bit   (field_bit),
        .block_pos_x (block_pos_x),
        .block_pos_y (block_pos_y),
        .rotate_out  (rotate_out),
        .b_x         (b_x),
        .b_y         (b_y),
        .field_req   (field_req),
        .busy        (busy),
        .done        (done),
        .collide     (collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index register stage, then field RAM / shape ROM read stage.
    always @(posedge clk) begin
        int ix;
        int iy;
        ix = int'(block_pos_x) + int'(b_x);
        iy = int'(block_pos_y) + int'(b_y);
        sh1 <= shape_rom[rotate_out][{b_y, b_x}];
        fb1 <= (ix >= 20 || iy >= 24) ? 1'b1 : fmem[iy*20 + ix];
        shape_bit <= sh1;
        field_bit <= fb1;
    end

    task automatic check(input logic [31:0] obs,
                         input logic [31:0] exp,
                         input string tag);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_shape(input logic [15:0] m0,
                             input logic [15:0] m1);
        shape_rom[0] = m0;
        shape_rom[1] = m1;
        shape_rom[2] = 16'h0000;
        shape_rom[3] = 16'h0000;
    endtask

    task automatic run_scan(input logic [4:0] px,
                            input logic [4:0] py,
                            input logic [1:0] r,
                            input int stall_len,
                            input int ign_at,
                            input int exp_lat,
                            input logic exp_col,
                            input string tag);
        int  n;
        int  issued;
        int  stalled;
        bit  seen;
        n = 0;
        issued = 0;
        stalled = 0;
        seen = 0;
        @(negedge clk);
        pos_x = px;
        pos_y = py;
        rot = r;
        start = 1'b1;
        field_gnt = 1'b1;
        @(posedge clk);
        #1;
        check(32'(busy), 32'd1, {tag, "_busy"});
        while (!seen && n < 80) begin
            @(negedge clk);
            start = 1'b0;
            if (n == ign_at) begin
                start = 1'b1;
                pos_x = px + 5'd3;
            end
            if (issued == 3 && stalled < stall_len) begin
                field_gnt = 1'b0;
                stalled++;
            end else begin
                field_gnt = 1'b1;
            end
            if (field_req) begin
                check(32'({b_y, b_x}), 32'(issued[3:0]),
                      field_gnt ? {tag, "_order"} : {tag, "_frozen"});
                if (field_gnt) issued++;
            end
            @(posedge clk);
            #1;
            n++;
            if (done) seen = 1;
        end
        start = 1'b0;
        check(32'(seen), 32'd1, {tag, "_timeout"});
        check(32'(n), 32'(exp_lat), {tag, "_latency"});
        check(32'(collide), 32'(exp_col), {tag, "_collide"});
        check(32'(issued), 32'd16, {tag, "_issues"});
        check(32'(block_pos_x), 32'(px), {tag, "_posx"});
        @(posedge clk);
        #1;
        check(32'(done), 32'd0, {tag, "_done_pulse"});
        check(32'(busy), 32'd0, {tag, "_idle"});
        check(32'(collide), 32'(exp_col), {tag, "_hold"});
    endtask

    initial begin
        int dn;
        fmem = '0;
        set_shape(16'h0660, 16'h0000);
        rst_n = 1'b0;
        start = 1'b0;
        pos_x = '0;
        pos_y = '0;
        rot = '0;
        field_gnt = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(32'(busy), 32'd0, "rst_busy");
        check(32'(done), 32'd0, "rst_done");
        check(32'(collide), 32'd0, "rst_collide");
        check(32'(field_req), 32'd0, "rst_req");
        check(32'({b_y, b_x}), 32'd0, "rst_cell");
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(5'd5, 5'd5, 2'd0, 0, -1, 19, 1'b0, "o_empty");

        fmem[6*20 + 6] = 1'b1;
        run_scan(5'd5, 5'd5, 2'd0, 0, -1, 19, 1'b1, "o_hit");
        repeat (3) @(posedge clk);
        #1;
        check(32'(collide), 32'd1, "o_hit_held");

        fmem[6*20 + 6] = 1'b0;
        run_scan(5'd8, 5'd5, 2'd0, 0, -1, 19, 1'b0, "o_moved");

        set_shape(16'h0000, 16'h00F0);
        run_scan(5'd17, 5'd5, 2'd1, 0, -1, 19, 1'b1, "i_horiz");

        set_shape(16'h2222, 16'h0000);
        run_scan(5'd18, 5'd5, 2'd0, 0, -1, 19, 1'b0, "i_vert");

        set_shape(16'h0660, 16'h0000);
        fmem[6*20 + 6] = 1'b1;
        run_scan(5'd5, 5'd5, 2'd0, 5, -1, 24, 1'b1, "stall");

        run_scan(5'd5, 5'd5, 2'd0, 0, 4, 19, 1'b1, "ign_start");

        @(negedge clk);
        pos_x = 5'd5;
        pos_y = 5'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check(32'(busy), 32'd0, "mid_rst_busy");
        check(32'(done), 32'd0, "mid_rst_done");
        check(32'(collide), 32'd0, "mid_rst_collide");
        check(32'(field_req), 32'd0, "mid_rst_req");
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) dn++;
        end
        check(32'(dn), 32'd0, "mid_rst_no_done");

        fmem = '0;
        set_shape(16'h00FF, 16'h0000);
        run_scan(5'd5, 5'd22, 2'd0, 0, -1, 19, 1'b0, "y_edge_in");
        set_shape(16'h0100, 16'h0000);
        run_scan(5'd5, 5'd22, 2'd0, 0, -1, 19, 1'b1, "y_edge_oob");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
